// File: rtl/n_term_ram_io_loopback_pkg.sv
// Shared types and constants for the north-terminal RAM_IO wire turnaround tile.
package fab_term_pkg;

  typedef enum logic [1:0] {
    MODE_COMB = 2'b00,
    MODE_REG1 = 2'b01,
    MODE_REG2 = 2'b10,
    MODE_TIE0 = 2'b11
  } term_mode_e;

  localparam int CFG_BITS = 8;
  localparam int GRP_S1   = 0;
  localparam int GRP_S2   = 1;
  localparam int GRP_S2B  = 2;
  localparam int GRP_S4   = 3;

endpackage

// File: rtl/n_term_ram_io_loopback_if.sv
// Wire groups plus the serial config port of the north-terminal loopback tile.
interface n_term_ram_io_loopback_if #(
  parameter int W1 = 4,
  parameter int W2 = 8,
  parameter int W4 = 16
);
  logic [W1-1:0] N1END;
  logic [W2-1:0] N2MID;
  logic [W2-1:0] N2END;
  logic [W4-1:0] N4END;
  logic [W1-1:0] S1BEG;
  logic [W2-1:0] S2BEG;
  logic [W2-1:0] S2BEGb;
  logic [W4-1:0] S4BEG;
  logic          cfg_en;
  logic          cfg_data;
  logic          cfg_commit;
  logic          cfg_out;
  logic          cfg_ready;
  logic          cfg_err;

  modport master (
    output N1END, N2MID, N2END, N4END, cfg_en, cfg_data, cfg_commit,
    input  S1BEG, S2BEG, S2BEGb, S4BEG, cfg_out, cfg_ready, cfg_err
  );

  modport slave (
    input  N1END, N2MID, N2END, N4END, cfg_en, cfg_data, cfg_commit,
    output S1BEG, S2BEG, S2BEGb, S4BEG, cfg_out, cfg_ready, cfg_err
  );
endinterface

// File: rtl/n_term_ram_io_loopback_stage.sv
// One wire group: index reversal, two always-running pipeline stages, mode-selected output.
module term_wire_stage
  import fab_term_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         UserCLK,
  input  logic         resetn,
  input  logic [W-1:0] in,
  input  logic [1:0]   mode,
  output logic [W-1:0] out
);
  logic [W-1:0] rev, st1, st2;

  for (genvar i = 0; i < W; i++) begin : g_rev
    assign rev[i] = in[W-1-i];
  end

  // Stages run regardless of mode, so a mode switch exposes existing history.
  always_ff @(posedge UserCLK) begin
    if (!resetn) begin
      st1 <= '0;
      st2 <= '0;
    end else begin
      st1 <= rev;
      st2 <= st1;
    end
  end

  always_comb begin
    out = rev;
    case (term_mode_e'(mode))
      MODE_COMB: out = rev;
      MODE_REG1: out = st1;
      MODE_REG2: out = st2;
      MODE_TIE0: out = '0;
      default:   out = rev;
    endcase
  end
endmodule

// File: rtl/n_term_ram_io_loopback.sv
// North-terminal RAM_IO loopback: N wires return as index-reversed S wires, modes loaded
// through a count-checked serial shadow register.
module n_term_ram_io_loopback
  import fab_term_pkg::*;
#(
  parameter int W1 = 4,
  parameter int W2 = 8,
  parameter int W4 = 16
) (
  input logic UserCLK,
  input logic resetn,
  n_term_ram_io_loopback_if.slave io
);
  logic [CFG_BITS-1:0] shadow, active;
  logic [3:0]          cnt;
  logic                err;
  logic                accept;

  assign io.cfg_out   = shadow[CFG_BITS-1];
  assign io.cfg_ready = (cnt == 4'(CFG_BITS));
  assign io.cfg_err   = err;
  assign accept       = io.cfg_commit && io.cfg_ready;

  // A commit sees the pre-shift shadow; a same-cycle shift counts toward the next load.
  always_ff @(posedge UserCLK) begin
    if (!resetn) begin
      shadow <= '0;
      active <= '0;
      cnt    <= '0;
      err    <= 1'b0;
    end else begin
      if (io.cfg_en)
        shadow <= {shadow[CFG_BITS-2:0], io.cfg_data};
      if (accept) begin
        active <= shadow;
        cnt    <= io.cfg_en ? 4'd1 : 4'd0;
      end else if (io.cfg_en && cnt != 4'hF) begin
        cnt <= cnt + 4'd1;
      end
      if (io.cfg_commit && !io.cfg_ready)
        err <= 1'b1;
    end
  end

  term_wire_stage #(.W(W1)) u_s1 (
    .UserCLK(UserCLK), .resetn(resetn), .in(io.N1END),
    .mode(active[2*GRP_S1 +: 2]), .out(io.S1BEG));

  term_wire_stage #(.W(W2)) u_s2 (
    .UserCLK(UserCLK), .resetn(resetn), .in(io.N2MID),
    .mode(active[2*GRP_S2 +: 2]), .out(io.S2BEG));

  term_wire_stage #(.W(W2)) u_s2b (
    .UserCLK(UserCLK), .resetn(resetn), .in(io.N2END),
    .mode(active[2*GRP_S2B +: 2]), .out(io.S2BEGb));

  term_wire_stage #(.W(W4)) u_s4 (
    .UserCLK(UserCLK), .resetn(resetn), .in(io.N4END),
    .mode(active[2*GRP_S4 +: 2]), .out(io.S4BEG));
endmodule

// File: tb/tb_n_term_ram_io_loopback.sv
// Scoreboard bench: the driver predicts each cycle's outputs from a behavioural model,
// a monitor compares them against the tile mid-cycle.
module tb_n_term_ram_io_loopback;
  localparam int W1 = 4;
  localparam int W2 = 8;
  localparam int W4 = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  n_term_ram_io_loopback_if #(.W1(W1), .W2(W2), .W4(W4)) io();

  n_term_ram_io_loopback #(.W1(W1), .W2(W2), .W4(W4)) dut (
    .UserCLK(clk), .resetn(rstn), .io(io.slave));

  typedef struct {
    logic [15:0] s1, s2, s2b, s4;
    logic co, rdy, er;
  } exp_t;

  exp_t sbq[$];
  event ev;
  int checks = 0;
  int errors = 0;

  // Model: shadow as the last 8 shifted bits (oldest first), shifts since last load,
  // per-group mode, and per-group history of reversed inputs (most recent first).
  bit          sh[$];
  int          nsh;
  bit          merr;
  int          md[4];
  logic [15:0] past[4][$];
  int          wid[4] = '{W1, W2, W2, W4};

  function automatic logic [15:0] rev(input logic [15:0] v, input int w);
    logic [15:0] r = '0;
    for (int i = 0; i < w; i++) r[i] = v[w-1-i];
    return r;
  endfunction

  function automatic void reset_model();
    sh.delete();
    for (int i = 0; i < 8; i++) sh.push_back(1'b0);
    nsh = 0;
    merr = 1'b0;
    for (int g = 0; g < 4; g++) begin
      md[g] = 0;
      past[g].delete();
    end
  endfunction

  function automatic logic [15:0] grp_out(input int g, input logic [15:0] cur);
    case (md[g])
      0: return rev(cur, wid[g]);
      1: return (past[g].size() > 0) ? past[g][0] : 16'h0;
      2: return (past[g].size() > 1) ? past[g][1] : 16'h0;
      default: return 16'h0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic d, input logic c,
                      input logic [15:0] a1, input logic [15:0] a2,
                      input logic [15:0] a3, input logic [15:0] a4);
    logic [15:0] cur[4];
    exp_t x;
    cur[0] = {12'h0, a1[W1-1:0]};
    cur[1] = {8'h0, a2[W2-1:0]};
    cur[2] = {8'h0, a3[W2-1:0]};
    cur[3] = a4;
    @(negedge clk);
    rstn = r;
    io.cfg_en = e;
    io.cfg_data = d;
    io.cfg_commit = c;
    io.N1END = cur[0][W1-1:0];
    io.N2MID = cur[1][W2-1:0];
    io.N2END = cur[2][W2-1:0];
    io.N4END = cur[3];
    #1;
    x.s1 = grp_out(0, cur[0]);
    x.s2 = grp_out(1, cur[1]);
    x.s2b = grp_out(2, cur[2]);
    x.s4 = grp_out(3, cur[3]);
    x.co = sh[0];
    x.rdy = (nsh == 8);
    x.er = merr;
    sbq.push_back(x);
    -> ev;
    @(posedge clk);
    if (!r) begin
      reset_model();
    end else begin
      if (c) begin
        if (nsh == 8) begin
          for (int g = 0; g < 4; g++) md[g] = 2 * int'(sh[7-(2*g+1)]) + int'(sh[7-2*g]);
          nsh = 0;
        end else begin
          merr = 1'b1;
        end
      end
      if (e) begin
        sh.push_back(d);
        void'(sh.pop_front());
        nsh++;
      end
      for (int g = 0; g < 4; g++) begin
        past[g].push_front(rev(cur[g], wid[g]));
        if (past[g].size() > 2) void'(past[g].pop_back());
      end
    end
  endtask

  task automatic rstep(input logic r, input logic e, input logic d, input logic c);
    step(r, e, d, c, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
  endtask

  task automatic shift_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) rstep(1'b1, 1'b1, b[i], 1'b0);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(ev);
      #1;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: got empty queue expected entry at %0t", $time);
      end else begin
        x = sbq.pop_front();
        chk("S1BEG",  {12'h0, io.S1BEG},  x.s1);
        chk("S2BEG",  {8'h0, io.S2BEG},   x.s2);
        chk("S2BEGb", {8'h0, io.S2BEGb},  x.s2b);
        chk("S4BEG",  io.S4BEG,           x.s4);
        chk("cfg_out",   {15'h0, io.cfg_out},   {15'h0, x.co});
        chk("cfg_ready", {15'h0, io.cfg_ready}, {15'h0, x.rdy});
        chk("cfg_err",   {15'h0, io.cfg_err},   {15'h0, x.er});
      end
    end
  end

  initial begin : driver
    io.cfg_en = 1'b0;
    io.cfg_data = 1'b0;
    io.cfg_commit = 1'b0;
    io.N1END = '0;
    io.N2MID = '0;
    io.N2END = '0;
    io.N4END = '0;
    reset_model();

    // reset, then combinational reversal straight away
    rstep(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h1, 16'h0, 16'h0, 16'h8000);
    repeat (2) rstep(1'b1, 1'b0, 1'b0, 1'b0);

    // S4=REG1, S2b=REG2, S2=TIE0, S1=COMB
    shift_byte(8'b01_10_11_00);
    rstep(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (6) rstep(1'b1, 1'b0, 1'b0, 1'b0);

    // 7 shifts then commit: rejected; one more shift then commit: accepted, err sticky
    rstep(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) rstep(1'b1, 1'b1, 1'($urandom), 1'b0);
    rstep(1'b1, 1'b0, 1'b0, 1'b1);
    rstep(1'b1, 1'b1, 1'b1, 1'b0);
    rstep(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) rstep(1'b1, 1'b0, 1'b0, 1'b0);

    // 9 shifts then commit rejected; 20 shifts never wrap back to ready
    rstep(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) rstep(1'b1, 1'b1, 1'($urandom), 1'b0);
    rstep(1'b1, 1'b0, 1'b0, 1'b1);
    rstep(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) rstep(1'b1, 1'b1, 1'($urandom), 1'b0);
    rstep(1'b1, 1'b0, 1'b0, 1'b1);

    // accepted commit with a same-cycle shift: counter restarts at 1
    rstep(1'b0, 1'b0, 1'b0, 1'b0);
    shift_byte(8'b11_01_10_01);
    rstep(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) rstep(1'b1, 1'b1, 1'($urandom), 1'b0);
    rstep(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) rstep(1'b1, 1'b0, 1'b0, 1'b0);

    // REG2 on S2BEGb, reset mid-pipeline
    rstep(1'b0, 1'b0, 1'b0, 1'b0);
    shift_byte(8'b00_10_00_00);
    rstep(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h01, 16'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h02, 16'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h03, 16'h0);
    repeat (3) rstep(1'b1, 1'b0, 1'b0, 1'b0);

    // randomized mix of loads, stray shifts/commits and resets
    for (int n = 0; n < 300; n++) begin
      int sel = int'($urandom_range(0, 39));
      if (sel == 0) begin
        rstep(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
      end else if (sel < 6) begin
        shift_byte(8'($urandom));
        rstep(1'b1, 1'($urandom), 1'($urandom), 1'b1);
      end else begin
        rstep(1'b1, ($urandom_range(0, 1) == 0), 1'($urandom),
              ($urandom_range(0, 15) == 0));
      end
    end

    repeat (2) @(negedge clk);
    #3;
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
